// File: rtl/pe_select_sequencer.sv
// pe_select_sequencer: registered PE-select stream generator (direct / scan-up / scan-down / broadcast).
// Define PE_SEL_RANGE_CHECK_EN to reject non-broadcast commands whose address is >= NUM_PE.
module pe_select_sequencer #(
   parameter int NUM_PE     = 8,
   parameter int ADDR_WIDTH = $clog2(NUM_PE),
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_mode,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [CNT_WIDTH-1:0]  cmd_count,
   output logic                  sel_valid,
   input  logic                  sel_ready,
   output logic [NUM_PE-1:0]     sel_onehot,
   output logic [ADDR_WIDTH-1:0] sel_addr,
   output logic                  sel_last,
   output logic                  busy,
   output logic                  cmd_err
);

   localparam logic [1:0] MODE_DIRECT    = 2'd0;
   localparam logic [1:0] MODE_SCAN_UP   = 2'd1;
   localparam logic [1:0] MODE_SCAN_DOWN = 2'd2;
   localparam logic [1:0] MODE_BROADCAST = 2'd3;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(NUM_PE - 1);

   logic                  state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [NUM_PE-1:0]     onehot_q, onehot_d;
   logic [ADDR_WIDTH-1:0] first_addr, step_addr;
   logic                  beat_done, last_done, accept, reject;

   function automatic logic [NUM_PE-1:0] decode(input logic [1:0] mode,
                                                input logic [ADDR_WIDTH-1:0] addr);
      logic [NUM_PE-1:0] oh;
      oh = '0;
      if (mode == MODE_BROADCAST) begin
         oh = '1;
      end else begin
         // Out-of-range addresses match no bit and therefore select no PE.
         for (int i = 0; i < NUM_PE; i++) begin
            if (addr == ADDR_WIDTH'(i)) oh[i] = 1'b1;
         end
      end
      return oh;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [1:0] mode,
                                                       input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] nxt;
      case (mode)
         MODE_DIRECT:    nxt = addr;
         MODE_SCAN_UP:   nxt = (int'(addr) >= NUM_PE - 1) ? '0 : addr + ADDR_WIDTH'(1);
         MODE_SCAN_DOWN: nxt = (addr == '0 || int'(addr) > NUM_PE - 1) ? MAX_ADDR
                                                                       : addr - ADDR_WIDTH'(1);
         default:        nxt = '0;
      endcase
      return nxt;
   endfunction

`ifdef PE_SEL_RANGE_CHECK_EN
   logic err_q, err_d;
   assign reject  = (cmd_mode != MODE_BROADCAST) && (int'(cmd_addr) >= NUM_PE);
   assign err_d   = accept && reject;
   assign cmd_err = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end
`else
   assign reject  = 1'b0;
   assign cmd_err = 1'b0;
`endif

   always_comb begin
      beat_done  = (state_q == ST_RUN) && sel_ready;
      last_done  = beat_done && (remaining_q == '0);
      cmd_ready  = (state_q == ST_IDLE) || last_done;
      accept     = cmd_valid && cmd_ready;
      first_addr = (cmd_mode == MODE_BROADCAST) ? '0 : cmd_addr;
      step_addr  = next_addr(mode_q, addr_q);

      // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
      state_d     = state_q;
      mode_d      = mode_q;
      remaining_d = remaining_q;
      addr_d      = addr_q;
      onehot_d    = onehot_q;

      if (beat_done) begin
         if (remaining_q == '0) begin
            state_d  = ST_IDLE;
            onehot_d = '0;
         end else begin
            remaining_d = remaining_q - CNT_WIDTH'(1);
            addr_d      = step_addr;
            onehot_d    = decode(mode_q, step_addr);
         end
      end

      // A new command overrides the return to IDLE when it lands on the final beat.
      if (accept && !reject) begin
         state_d     = ST_RUN;
         mode_d      = cmd_mode;
         remaining_d = cmd_count;
         addr_d      = first_addr;
         onehot_d    = decode(cmd_mode, first_addr);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_DIRECT;
         remaining_q <= '0;
         addr_q      <= '0;
         onehot_q    <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         onehot_q    <= onehot_d;
      end
   end

   assign sel_valid  = (state_q == ST_RUN);
   assign busy       = (state_q == ST_RUN);
   assign sel_addr   = addr_q;
   assign sel_onehot = onehot_q;
   assign sel_last   = (state_q == ST_RUN) && (remaining_q == '0);

endmodule

// File: tb/tb_pe_select_sequencer.sv
// Scoreboard bench for pe_select_sequencer: two instances (NUM_PE=8 and NUM_PE=6) driven by
// directed and random commands; expected beats come from a arithmetic reference model.
module tb_pe_select_sequencer;

   localparam int AW = 3;
   localparam int CW = 8;

   localparam int M_DIRECT    = 0;
   localparam int M_SCAN_UP   = 1;
   localparam int M_SCAN_DOWN = 2;
   localparam int M_BROADCAST = 3;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    onehot;
      logic          last;
   } beat_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          cmd_valid [2];
   logic          cmd_ready [2];
   logic [1:0]    cmd_mode  [2];
   logic [AW-1:0] cmd_addr  [2];
   logic [CW-1:0] cmd_count [2];
   logic          sel_valid [2];
   logic          sel_ready [2];
   logic [AW-1:0] sel_addr  [2];
   logic          sel_last  [2];
   logic          busy      [2];
   logic          cmd_err   [2];
   logic [7:0]    oh8;
   logic [5:0]    oh6;
   logic [7:0]    sel_onehot [2];

   assign sel_onehot[0] = oh8;
   assign sel_onehot[1] = {2'b00, oh6};

   pe_select_sequencer #(.NUM_PE(8), .CNT_WIDTH(CW)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_mode(cmd_mode[0]),
      .cmd_addr(cmd_addr[0]), .cmd_count(cmd_count[0]),
      .sel_valid(sel_valid[0]), .sel_ready(sel_ready[0]), .sel_onehot(oh8),
      .sel_addr(sel_addr[0]), .sel_last(sel_last[0]), .busy(busy[0]), .cmd_err(cmd_err[0])
   );

   pe_select_sequencer #(.NUM_PE(6), .CNT_WIDTH(CW)) u_dut6 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_mode(cmd_mode[1]),
      .cmd_addr(cmd_addr[1]), .cmd_count(cmd_count[1]),
      .sel_valid(sel_valid[1]), .sel_ready(sel_ready[1]), .sel_onehot(oh6),
      .sel_addr(sel_addr[1]), .sel_last(sel_last[1]), .busy(busy[1]), .cmd_err(cmd_err[1])
   );

   beat_t exp0 [$];
   beat_t exp1 [$];
   beat_t stage_q [$];

   int    n_checks = 0;
   int    n_fail   = 0;
   int    beats_done  [2];
   logic  err_pending [2];
   logic  stall_prev  [2];
   beat_t prev_beat   [2];
   int    rdy_mode    [2];
   int    rdy_phase   [2];

   task automatic check(input string name, input int d, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at t=%0t", name, d, act, exp, $time);
      end
   endtask

   function automatic int num_pe(input int d);
      return (d == 0) ? 8 : 6;
   endfunction

   function automatic int q_size(input int d);
      return (d == 0) ? exp0.size() : exp1.size();
   endfunction

   task automatic q_push(input int d, input beat_t b);
      if (d == 0) exp0.push_back(b);
      else        exp1.push_back(b);
   endtask

   task automatic q_pop(input int d, output beat_t b);
      if (d == 0) b = exp0.pop_front();
      else        b = exp1.pop_front();
   endtask

   task automatic q_clear(input int d);
      if (d == 0) exp0.delete();
      else        exp1.delete();
   endtask

   // Reference model: the address walk expressed with modular arithmetic.
   task automatic push_cmd(input int d, input int mode, input int addr, input int count);
      int    n;
      int    a;
      beat_t b;
      n = num_pe(d);
`ifdef PE_SEL_RANGE_CHECK_EN
      if (mode != M_BROADCAST && addr >= n) begin
         err_pending[d] = 1'b1;
         return;
      end
`endif
      a = (mode == M_BROADCAST) ? 0 : addr;
      for (int k = 0; k <= count; k++) begin
         b.addr = AW'(a);
         if (mode == M_BROADCAST) b.onehot = 8'((1 << n) - 1);
         else if (a < n)          b.onehot = 8'(1 << a);
         else                     b.onehot = 8'h00;
         b.last = (k == count);
         q_push(d, b);
         if (mode == M_SCAN_UP)        a = (a < n) ? (a + 1) % n : 0;
         else if (mode == M_SCAN_DOWN) a = (a < n) ? (a + n - 1) % n : n - 1;
      end
   endtask

   // Issue one command; expectations are queued at the cycle it is accepted.
   task automatic send(input int d, input int mode, input int addr, input int count,
                       input bit use_model);
      bit got;
      got = 1'b0;
      @(negedge clk);
      cmd_valid[d] = 1'b1;
      cmd_mode[d]  = 2'(mode);
      cmd_addr[d]  = AW'(addr);
      cmd_count[d] = CW'(count);
      for (int c = 0; c < 2000 && !got; c++) begin
         #1;
         if (cmd_ready[d]) begin
            got = 1'b1;
            if (use_model) push_cmd(d, mode, addr, count);
            else while (stage_q.size() != 0) q_push(d, stage_q.pop_front());
            @(posedge clk);
         end else begin
            @(negedge clk);
         end
      end
      check("cmd_accepted", d, 32'(got), 32'd1);
      #1;
      cmd_valid[d] = 1'b0;
      cmd_mode[d]  = 2'($urandom);
      cmd_addr[d]  = AW'($urandom);
      cmd_count[d] = CW'($urandom);
   endtask

   task automatic wait_idle(input int d);
      int c;
      c = 0;
      while (c < 3000 && (q_size(d) != 0 || sel_valid[d])) begin
         @(negedge clk);
         #2;
         c++;
      end
      check("drain", d, 32'(q_size(d)), 32'd0);
   endtask

   task automatic check_idle_outputs(input int d);
      check("rst_sel_valid",  d, 32'(sel_valid[d]),  32'd0);
      check("rst_sel_onehot", d, 32'(sel_onehot[d]), 32'd0);
      check("rst_sel_addr",   d, 32'(sel_addr[d]),   32'd0);
      check("rst_sel_last",   d, 32'(sel_last[d]),   32'd0);
      check("rst_busy",       d, 32'(busy[d]),       32'd0);
      check("rst_cmd_err",    d, 32'(cmd_err[d]),    32'd0);
      check("rst_cmd_ready",  d, 32'(cmd_ready[d]),  32'd1);
   endtask

   task automatic mon_step(input int d);
      beat_t e;
      check("valid_vs_pending", d, 32'(sel_valid[d]), 32'(q_size(d) != 0));
      check("busy_vs_pending",  d, 32'(busy[d]),      32'(q_size(d) != 0));
      if (stall_prev[d]) begin
         check("hold_addr",   d, 32'(sel_addr[d]),   32'(prev_beat[d].addr));
         check("hold_onehot", d, 32'(sel_onehot[d]), 32'(prev_beat[d].onehot));
         check("hold_last",   d, 32'(sel_last[d]),   32'(prev_beat[d].last));
      end
      if (sel_valid[d] && sel_ready[d]) begin
         check("beat_expected", d, 32'(q_size(d) != 0), 32'd1);
         if (q_size(d) != 0) begin
            q_pop(d, e);
            check("beat_addr",   d, 32'(sel_addr[d]),   32'(e.addr));
            check("beat_onehot", d, 32'(sel_onehot[d]), 32'(e.onehot));
            check("beat_last",   d, 32'(sel_last[d]),   32'(e.last));
            beats_done[d]++;
         end
      end
      stall_prev[d] = sel_valid[d] && !sel_ready[d];
      prev_beat[d]  = '{addr: sel_addr[d], onehot: sel_onehot[d], last: sel_last[d]};
      if (cmd_err[d] || err_pending[d]) check("cmd_err", d, 32'(cmd_err[d]), 32'(err_pending[d]));
      err_pending[d] = 1'b0;
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_side
      always @(negedge clk) if (rst_n) mon_step(g);

      // Consumer back-pressure: 0 always ready, 1 random, 2 repeating 1,0,0.
      initial begin
         sel_ready[g] = 1'b1;
         forever begin
            @(posedge clk);
            #1;
            case (rdy_mode[g])
               0:       sel_ready[g] = 1'b1;
               1:       sel_ready[g] = 1'($urandom_range(0, 1));
               default: begin
                  sel_ready[g] = (rdy_phase[g] % 3 == 0);
                  rdy_phase[g]++;
               end
            endcase
         end
      end
   end

   task automatic rand_run(input int d);
      for (int i = 0; i < 40; i++) begin
         send(d, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 5), 1'b1);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      wait_idle(d);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      for (int d = 0; d < 2; d++) begin
         cmd_valid[d]   = 1'b0;
         cmd_mode[d]    = 2'd0;
         cmd_addr[d]    = '0;
         cmd_count[d]   = '0;
         beats_done[d]  = 0;
         err_pending[d] = 1'b0;
         stall_prev[d]  = 1'b0;
         prev_beat[d]   = '0;
         rdy_mode[d]    = 0;
         rdy_phase[d]   = 0;
      end
      #3;
      check_idle_outputs(0);
      check_idle_outputs(1);
      #9 rst_n = 1'b1;

      // Single DIRECT beat on PE 5.
      stage_q.push_back('{addr: 3'd5, onehot: 8'b0010_0000, last: 1'b1});
      send(0, M_DIRECT, 5, 0, 1'b0);
      wait_idle(0);

      // SCAN_UP wrapping past the top of an 8-PE bank.
      stage_q.push_back('{addr: 3'd6, onehot: 8'h40, last: 1'b0});
      stage_q.push_back('{addr: 3'd7, onehot: 8'h80, last: 1'b0});
      stage_q.push_back('{addr: 3'd0, onehot: 8'h01, last: 1'b0});
      stage_q.push_back('{addr: 3'd1, onehot: 8'h02, last: 1'b1});
      send(0, M_SCAN_UP, 6, 3, 1'b0);
      wait_idle(0);

      // SCAN_DOWN wrapping on a 6-PE bank, then a back-to-back BROADCAST.
      stage_q.push_back('{addr: 3'd1, onehot: 8'h02, last: 1'b0});
      stage_q.push_back('{addr: 3'd0, onehot: 8'h01, last: 1'b0});
      stage_q.push_back('{addr: 3'd5, onehot: 8'h20, last: 1'b1});
      send(1, M_SCAN_DOWN, 1, 2, 1'b0);
      stage_q.push_back('{addr: 3'd0, onehot: 8'h3f, last: 1'b0});
      stage_q.push_back('{addr: 3'd0, onehot: 8'h3f, last: 1'b1});
      send(1, M_BROADCAST, 4, 1, 1'b0);
      wait_idle(1);

      // Stalled SCAN_UP: exactly five beats delivered.
      @(negedge clk);
      rdy_phase[1] = 0;
      rdy_mode[1]  = 2;
      start = beats_done[1];
      send(1, M_SCAN_UP, 3, 4, 1'b1);
      wait_idle(1);
      check("stall_beat_count", 1, 32'(beats_done[1] - start), 32'd5);
      rdy_mode[1] = 0;

      // Out-of-range DIRECT on the 6-PE bank (rejected or an all-zero beat, by build).
      send(1, M_DIRECT, 7, 0, 1'b1);
      wait_idle(1);
      send(1, M_SCAN_DOWN, 6, 2, 1'b1);
      wait_idle(1);
      repeat (2) @(negedge clk);

      // Asynchronous reset in the middle of a long scan.
      start = beats_done[0];
      send(0, M_SCAN_UP, 0, 7, 1'b1);
      for (int c = 0; c < 100 && beats_done[0] < start + 2; c++) @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs(0);
      check_idle_outputs(1);
      for (int d = 0; d < 2; d++) begin
         q_clear(d);
         err_pending[d] = 1'b0;
         stall_prev[d]  = 1'b0;
      end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      #1 check("cmd_ready_after_reset", 0, 32'(cmd_ready[0]), 32'd1);
      send(0, M_DIRECT, 2, 1, 1'b1);
      wait_idle(0);

      // Maximum count produces 2^CNT_WIDTH beats.
      start = beats_done[0];
      send(0, M_SCAN_DOWN, 3, 255, 1'b1);
      wait_idle(0);
      check("max_count_beats", 0, 32'(beats_done[0] - start), 32'd256);

      // Randomized traffic on both instances concurrently.
      rdy_mode[0] = 1;
      rdy_mode[1] = 1;
      fork
         rand_run(0);
         rand_run(1);
      join
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
